gtfmac_vnc_event_xfer_tx: RTL and testbench

- Source-side endpoint of the toggle req/ack event-crossing protocol.
- Accumulates single-cycle events instead of dropping them while a handshake is outstanding.
- Presents the accumulated count as bundled data alongside a request toggle. The far-domain receiver samples the count on a toggle edge and returns an ack toggle.
- Sits in the clkin-side status/stat path of the GTFMAC VNC, wherever events must cross domains losslessly.

---
 rtl/gtfmac_vnc_xfer_pkg.sv | 19 +
 rtl/gtfmac_vnc_syncer_level.sv | 16 +
 rtl/gtfmac_vnc_event_xfer_tx.sv | 124 ++++++++++++
 tb/tb_gtfmac_vnc_event_xfer_tx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gtfmac_vnc_xfer_pkg.sv
// gtfmac_vnc_xfer_pkg: shared state type, default widths and saturating add
// for the event-crossing toggle req/ack source endpoint.
package gtfmac_vnc_xfer_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, GAP} xfer_state_t;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_GAP_CYC = 2;
    localparam int DEF_TO_CYC  = 1024;

    // Returns {saturated, value}; value is clamped to 2^w-1 (w <= 32).
    function automatic logic [32:0] sat_add(input logic [31:0] acc, input logic inc,
                                            input int unsigned w = DEF_CNT_W);
        logic [32:0] s;
        logic [32:0] mx;
        s  = {1'b0, acc} + {32'd0, inc};
        mx = (33'd1 << w) - 33'd1;
        return (s > mx) ? ({1'b1, 32'd0} | mx) : s;
    endfunction
endpackage

// File: rtl/gtfmac_vnc_syncer_level.sv
// gtfmac_vnc_syncer_level: two-flop level synchronizer, clears to 0 on reset.
module gtfmac_vnc_syncer_level (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/gtfmac_vnc_event_xfer_tx.sv
// gtfmac_vnc_event_xfer_tx: lossless event-count source for a toggle req/ack crossing.
// Define GTFMAC_VNC_EVENT_XFER_ACK_SYNC_EN to pass ack_toggle_in through a 2-flop synchronizer.
module gtfmac_vnc_event_xfer_tx
    import gtfmac_vnc_xfer_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int TO_CYC  = DEF_TO_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             event_in,
    input  logic             ack_toggle_in,
    input  logic             ovf_clr,
    output logic             req_toggle,
    output logic [CNT_W-1:0] bundle_cnt,
    output logic             busy,
    output logic [CNT_W-1:0] accum_cnt,
    output logic             ovf_sticky,
    output logic             timeout_sticky
);
    localparam int TO_W  = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TO_CYC);
    localparam logic [GAP_W-1:0] GAP_LD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    xfer_state_t      state_q, state_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] bundle_q, bundle_d;
    logic [CNT_W-1:0] accum_q, accum_d;
    logic             ovf_q, ovf_d;
    logic             to_flag_q, to_flag_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             busy_q, busy_d;
    logic             ack_v;
    logic [32:0]      sa;
    logic [CNT_W-1:0] sum;
    logic             sat;
    logic             unused_sa;

`ifdef GTFMAC_VNC_EVENT_XFER_ACK_SYNC_EN
    gtfmac_vnc_syncer_level u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (ack_toggle_in),
        .q_o   (ack_v)
    );
`else
    assign ack_v = ack_toggle_in;
`endif

    assign sa        = sat_add(32'(accum_q), event_in, CNT_W);
    assign sat       = sa[32];
    assign sum       = sa[CNT_W-1:0];
    assign unused_sa = ^(sa[31:0] >> CNT_W);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        bundle_d  = bundle_q;
        accum_d   = sum;
        gap_d     = gap_q;
        to_cnt_d  = to_cnt_q;
        to_flag_d = to_flag_q;
        ovf_d     = sat | (ovf_q & ~ovf_clr);
        unique case (state_q)
            IDLE: if (sum != '0) begin
                bundle_d = sum;
                accum_d  = '0;
                req_d    = ~req_q;
                to_cnt_d = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (TO_CYC != 0 && to_cnt_q != TO_MAX) begin
                    to_cnt_d  = to_cnt_q + TO_W'(1);
                    to_flag_d = to_flag_q | (to_cnt_d == TO_MAX);
                end
                if (ack_v == req_q) begin
                    state_d = (GAP_CYC == 0) ? IDLE : GAP;
                    gap_d   = GAP_LD;
                end
            end
            GAP: begin
                state_d = (gap_q == '0) ? IDLE : GAP;
                gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            bundle_q  <= '0;
            accum_q   <= '0;
            ovf_q     <= 1'b0;
            to_flag_q <= 1'b0;
            to_cnt_q  <= '0;
            gap_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            bundle_q  <= bundle_d;
            accum_q   <= accum_d;
            ovf_q     <= ovf_d;
            to_flag_q <= to_flag_d;
            to_cnt_q  <= to_cnt_d;
            gap_q     <= gap_d;
            busy_q    <= busy_d;
        end
    end

    assign req_toggle     = req_q;
    assign bundle_cnt     = bundle_q;
    assign busy           = busy_q;
    assign accum_cnt      = accum_q;
    assign ovf_sticky     = ovf_q;
    assign timeout_sticky = to_flag_q;
endmodule

// File: tb/tb_gtfmac_vnc_event_xfer_tx.sv
// tb_gtfmac_vnc_event_xfer_tx: random events and ack delays against a transaction-level model with a bundle scoreboard.
module tb_gtfmac_vnc_event_xfer_tx;
    localparam int CW  = 4;
    localparam int GC  = 2;
    localparam int TC  = 8;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          event_in = 1'b0;
    logic          ack_toggle_in = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          req_toggle;
    logic [CW-1:0] bundle_cnt;
    logic          busy;
    logic [CW-1:0] accum_cnt;
    logic          ovf_sticky;
    logic          timeout_sticky;

    int vecs = 0;
    int errs = 0;
    bit rx_en = 1'b1;

    int exp_q[$];
    int m_acc = 0;
    bit m_req = 1'b0;
    bit m_out = 1'b0;
    int m_hold = 0;
    int m_wc = 0;
    bit m_to = 1'b0;
    bit m_ovf = 1'b0;
    bit m_busy = 1'b0;
    bit [1:0] ack_h = '0;

    gtfmac_vnc_event_xfer_tx #(.CNT_W(CW), .GAP_CYC(GC), .TO_CYC(TC)) dut (
        .clk            (clk),
        .reset          (reset),
        .event_in       (event_in),
        .ack_toggle_in  (ack_toggle_in),
        .ovf_clr        (ovf_clr),
        .req_toggle     (req_toggle),
        .bundle_cnt     (bundle_cnt),
        .busy           (busy),
        .accum_cnt      (accum_cnt),
        .ovf_sticky     (ovf_sticky),
        .timeout_sticky (timeout_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: one outstanding request, a gap of GC edges after ack.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_acc = 0; m_req = 0; m_out = 0; m_hold = 0; m_wc = 0;
            m_to = 0; m_ovf = 0; m_busy = 0; ack_h = '0;
        end else begin
            bit av;
            bit s;
`ifdef GTFMAC_VNC_EVENT_XFER_ACK_SYNC_EN
            av = ack_h[1];
`else
            av = ack_toggle_in;
`endif
            s     = (m_acc == MAX) && event_in;
            m_acc = (m_acc == MAX) ? MAX : m_acc + int'(event_in);
            m_ovf = s || (m_ovf && !ovf_clr);
            if (m_out) begin
                if (m_wc < TC) m_wc++;
                if (m_wc == TC) m_to = 1;
                if (av == m_req) begin
                    m_out  = 0;
                    m_hold = GC;
                end
            end else if (m_hold > 0) begin
                m_hold--;
            end else if (m_acc != 0) begin
                exp_q.push_back(m_acc);
                m_acc = 0;
                m_req = !m_req;
                m_out = 1;
                m_wc  = 0;
            end
            ack_h  = {ack_h[0], ack_toggle_in};
            m_busy = m_out || (m_hold > 0);
        end
    end

    // Monitor: pops one expected bundle per observed request toggle.
    initial begin
        bit prev_req = 0;
        int last_b = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_req = 0;
                last_b = 0;
            end else begin
                if (req_toggle != prev_req) begin
                    if (exp_q.size() == 0) begin
                        vecs++; errs++;
                        $display("FAIL bundle_unexpected: got toggle with bundle %0d, required no toggle at %0t", bundle_cnt, $time);
                    end else begin
                        last_b = exp_q.pop_front();
                    end
                    prev_req = req_toggle;
                end
                chk("bundle_cnt", bundle_cnt, last_b);
                chk("req_toggle", req_toggle, m_req);
                chk("accum_cnt", accum_cnt, m_acc);
                chk("busy", busy, m_busy);
                chk("ovf_sticky", ovf_sticky, m_ovf);
                chk("timeout_sticky", timeout_sticky, m_to);
            end
        end
    end

    // Receiver: echoes the request toggle after a random delay.
    initial begin
        int dly = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) ack_toggle_in = 1'b0;
            else if (rx_en && req_toggle != ack_toggle_in) begin
                if (dly == 0) ack_toggle_in = req_toggle;
                else dly--;
            end else dly = $urandom_range(0, 5);
        end
    end

    task automatic drain();
        int n = 0;
        event_in = 0;
        ovf_clr = 0;
        rx_en = 1;
        while ((busy || accum_cnt != 0 || exp_q.size() != 0) && n < 200) begin
            step(1);
            n++;
        end
        chk("drain_done", n < 200, 1);
    endtask

    task automatic random_traffic(input int p, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            event_in = ($urandom_range(0, 99) < p);
            ovf_clr  = ($urandom_range(0, 39) == 0);
            step(1);
        end
    endtask

    initial begin
        step(3);
        reset = 1;
        step(2);
        event_in = 1;
        step(1);
        event_in = 0;
        chk("single_req", req_toggle, 1);
        chk("single_bundle", bundle_cnt, 1);
        chk("single_busy", busy, 1);
        step(15);
        random_traffic(10, 300);
        random_traffic(50, 300);
        random_traffic(95, 300);
        drain();

        rx_en = 0;
        event_in = 1;
        step(25);
        ovf_clr = 1;
        step(1);
        ovf_clr = 0;
        event_in = 0;
        step(1);
        chk("sat_accum", accum_cnt, MAX);
        chk("sat_ovf_hold", ovf_sticky, 1);
        chk("timeout_set", timeout_sticky, 1);
        ovf_clr = 1;
        step(1);
        ovf_clr = 0;
        chk("ovf_cleared", ovf_sticky, 0);
        drain();

        rx_en = 0;
        event_in = 1;
        step(1);
        event_in = 0;
        step(3);
        reset = 0;
        #1;
        chk("rst_req", req_toggle, 0);
        chk("rst_bundle", bundle_cnt, 0);
        chk("rst_accum", accum_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf_sticky, 0);
        chk("rst_timeout", timeout_sticky, 0);
        step(3);
        reset = 1;
        rx_en = 1;
        step(2);
        event_in = 1;
        step(1);
        event_in = 0;
        chk("post_rst_req", req_toggle, 1);
        chk("post_rst_bundle", bundle_cnt, 1);
        random_traffic(60, 300);
        drain();
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", errs);
        $fatal(1);
    end
endmodule
